// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, ExcCodes and the Cause write mask.
package cp0_pkg;

    localparam logic [4:0] CP0_REG_BADVADDR_ADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT_ADDR    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE_ADDR  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS_ADDR   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE_ADDR    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC_ADDR      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID_ADDR     = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG_ADDR   = 5'd16;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_HI   = 15;
    localparam int STATUS_IM_LO   = 8;
    localparam int CAUSE_BD_BIT   = 31;
    localparam int CAUSE_TI_BIT   = 30;
    localparam int CAUSE_IP_HI    = 15;
    localparam int CAUSE_IP_LO    = 8;
    localparam int CAUSE_EXC_HI   = 6;
    localparam int CAUSE_EXC_LO   = 2;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Only IV/WP-style bits 23:22 and the software IP bits 9:8 are writable by mtc0.
    localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with the sticky timer interrupt; a Compare write beats a same-cycle match.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tint_q, tint_d;

    always_comb begin
        count_d   = count_we_i ? wdata_i : count_q + 32'd1;
        compare_d = compare_we_i ? wdata_i : compare_q;
        tint_d    = tint_q;
        if (compare_we_i) begin
            tint_d = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            tint_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            tint_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tint_q    <= tint_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 system-control block with exception entry, ERET and registered interrupt request.
// Optional BadVAddr register (reg 8) is enabled by defining CP0_BADVADDR_EN.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter int          TIMER_IP   = 7,
    parameter logic [31:0] STATUS_RST = 32'h1000_0000,
    parameter logic [31:0] PRID_VAL   = 32'h0087_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            raddr_i,
    output logic [31:0]           rdata_o,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic [31:0]           exc_badvaddr_i,
    input  logic                  eret_i,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  timer_int_o,
`ifdef CP0_BADVADDR_EN
    output logic [31:0]           badvaddr_o,
`endif
    output logic                  int_req_o
);

    logic        timer_int;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic        bd_q, bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [3:0]  cause_wr_q, cause_wr_d;   // {Cause[23:22], Cause[9:8]}
    logic [7:2]  ip_hw_q, ip_hw_d;
    logic [7:2]  ti_mask;
    logic [7:0]  cause_ip;
    logic        int_req_q, int_req_d;

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (we_i && (waddr_i == CP0_REG_COUNT_ADDR)),
        .compare_we_i (we_i && (waddr_i == CP0_REG_COMPARE_ADDR)),
        .wdata_i      (wdata_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int)
    );

    always_comb begin
        ip_hw_d = '0;
        for (int k = 0; k < NUM_HW_INT; k++) begin
            ip_hw_d[k+2] = int_i[k];
        end
        ti_mask           = '0;
        ti_mask[TIMER_IP] = timer_int;
    end

    assign cause_ip = {ip_hw_q | ti_mask, cause_wr_q[1:0]};

    // Apply writers lowest-priority first so exception beats ERET beats mtc0.
    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        cause_wr_d = cause_wr_q;
        if (we_i) begin
            case (waddr_i)
                CP0_REG_STATUS_ADDR: status_d   = wdata_i;
                CP0_REG_CAUSE_ADDR:  cause_wr_d = {wdata_i[23:22], wdata_i[9:8]};
                CP0_REG_EPC_ADDR:    epc_d      = wdata_i;
                default: ;
            endcase
        end
        if (eret_i) begin
            status_d[STATUS_EXL_BIT] = 1'b0;
        end
        if (exc_valid_i) begin
            status_d[STATUS_EXL_BIT] = 1'b1;
            exccode_d                = exc_code_i;
            if (!status_q[STATUS_EXL_BIT]) begin
                epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                bd_d  = exc_bd_i;
            end
        end
        int_req_d = status_q[STATUS_IE_BIT] & ~status_q[STATUS_EXL_BIT]
                  & |(status_q[STATUS_IM_HI:STATUS_IM_LO] & cause_ip);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            epc_q      <= 32'd0;
            bd_q       <= 1'b0;
            exccode_q  <= 5'd0;
            cause_wr_q <= 4'd0;
            ip_hw_q    <= '0;
            int_req_q  <= 1'b0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            cause_wr_q <= cause_wr_d;
            ip_hw_q    <= ip_hw_d;
            int_req_q  <= int_req_d;
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr_q <= 32'd0;
        end else if (exc_valid_i && ((exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES))) begin
            badvaddr_q <= exc_badvaddr_i;
        end
    end

    assign badvaddr_o = badvaddr_q;
`else
    logic unused_badvaddr;
    assign unused_badvaddr = ^exc_badvaddr_i;
`endif

    assign status_o    = status_q;
    assign epc_o       = epc_q;
    assign timer_int_o = timer_int;
    assign int_req_o   = int_req_q;
    assign cause_o     = {bd_q, timer_int, 6'd0, cause_wr_q[3:2], 6'd0,
                          cause_ip, 1'b0, exccode_q, 2'd0};

    always_comb begin
        rdata_o = 32'd0;
        if (!rst) begin
            case (raddr_i)
`ifdef CP0_BADVADDR_EN
                CP0_REG_BADVADDR_ADDR: rdata_o = badvaddr_q;
`endif
                CP0_REG_COUNT_ADDR:    rdata_o = count_o;
                CP0_REG_COMPARE_ADDR:  rdata_o = compare_o;
                CP0_REG_STATUS_ADDR:   rdata_o = status_o;
                CP0_REG_CAUSE_ADDR:    rdata_o = cause_o;
                CP0_REG_EPC_ADDR:      rdata_o = epc_o;
                CP0_REG_PRID_ADDR:     rdata_o = PRID_VAL;
                CP0_REG_CONFIG_ADDR:   rdata_o = CONFIG_VAL;
                default:               rdata_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: register write/read table plus timer, interrupt, exception and reset sequences.
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  raddr_i = '0;
    logic [31:0] rdata_o;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [5:0]  int_i = '0;
    logic        exc_valid_i = 1'b0;
    logic [4:0]  exc_code_i = '0;
    logic [31:0] exc_pc_i = '0;
    logic        exc_bd_i = 1'b0;
    logic [31:0] exc_badvaddr_i = '0;
    logic        eret_i = 1'b0;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o;
    logic        timer_int_o, int_req_o;
`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cp0_exc_unit dut (
        .clk            (clk),
        .rst            (rst),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .int_i          (int_i),
        .exc_valid_i    (exc_valid_i),
        .exc_code_i     (exc_code_i),
        .exc_pc_i       (exc_pc_i),
        .exc_bd_i       (exc_bd_i),
        .exc_badvaddr_i (exc_badvaddr_i),
        .eret_i         (eret_i),
        .count_o        (count_o),
        .compare_o      (compare_o),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .timer_int_o    (timer_int_o),
`ifdef CP0_BADVADDR_EN
        .badvaddr_o     (badvaddr_o),
`endif
        .int_req_o      (int_req_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        we_i = 1'b1; waddr_i = addr; wdata_i = data;
        tick();
        we_i = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                       input logic [31:0] bad);
        exc_valid_i = 1'b1; exc_code_i = code; exc_pc_i = pc; exc_bd_i = bd;
        exc_badvaddr_i = bad;
        tick();
        exc_valid_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{5'd12, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF};
        vecs[1]  = '{5'd13, 32'hFFFF_FFFF, 5'd13, 32'h00C0_0300};
        vecs[2]  = '{5'd14, 32'hDEAD_BEEF, 5'd14, 32'hDEAD_BEEF};
        vecs[3]  = '{5'd15, 32'h1234_5678, 5'd15, 32'h0087_0102};
        vecs[4]  = '{5'd16, 32'h1234_5678, 5'd16, 32'h0000_8000};
        vecs[5]  = '{5'd20, 32'h1234_5678, 5'd20, 32'h0000_0000};
        vecs[6]  = '{5'd8,  32'h1234_5678, 5'd8,  32'h0000_0000};
        vecs[7]  = '{5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
        vecs[8]  = '{5'd11, 32'h0000_ABCD, 5'd11, 32'h0000_ABCD};
        vecs[9]  = '{5'd12, 32'h1000_0000, 5'd12, 32'h1000_0000};
        vecs[10] = '{5'd14, 32'h0000_0000, 5'd14, 32'h0000_0000};
        vecs[11] = '{5'd11, 32'h0000_0000, 5'd11, 32'h0000_0000};

        // Reset state
        raddr_i = 5'd12;
        tick(); tick();
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_count", count_o, 32'h0);
        check("rst_status", status_o, 32'h1000_0000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_int_req", {31'd0, int_req_o}, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_rdata_status", rdata_o, 32'h1000_0000);

        // Register write/read table
        for (int i = 0; i < 12; i++) begin
            mtc0(vecs[i].waddr, vecs[i].wdata);
            raddr_i = vecs[i].raddr;
            #1;
            check($sformatf("vec%0d_reg%0d", i, vecs[i].raddr), rdata_o, vecs[i].exp);
        end

        // Count load and wrap
        mtc0(5'd9, 32'h0000_0100);
        check("count_load", count_o, 32'h0000_0100);
        tick();
        check("count_inc", count_o, 32'h0000_0101);
        mtc0(5'd9, 32'hFFFF_FFFF);
        check("count_max", count_o, 32'hFFFF_FFFF);
        tick();
        check("count_wrap", count_o, 32'h0);

        // Timer match
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        repeat (10) tick();
        check("timer_count10", count_o, 32'd10);
        check("timer_not_yet", {31'd0, timer_int_o}, 32'h0);
        tick();
        check("timer_rise", {31'd0, timer_int_o}, 32'h1);
        check("cause_ip7", {31'd0, cause_o[15]}, 32'h1);
        check("cause_ti", {31'd0, cause_o[30]}, 32'h1);
        repeat (3) tick();
        check("timer_sticky", {31'd0, timer_int_o}, 32'h1);

        // Compare write in the match cycle wins
        mtc0(5'd11, 32'd20);
        check("timer_clear", {31'd0, timer_int_o}, 32'h0);
        mtc0(5'd9, 32'd17);
        repeat (3) tick();
        check("count20", count_o, 32'd20);
        mtc0(5'd11, 32'd20);
        check("timer_write_wins", {31'd0, timer_int_o}, 32'h0);
        tick();
        check("timer_still_low", {31'd0, timer_int_o}, 32'h0);
        mtc0(5'd11, 32'd0);

        // Interrupt request
        mtc0(5'd12, 32'h0000_0401);
        int_i = 6'b000001;
        tick(); tick();
        check("cause_ip2", {31'd0, cause_o[10]}, 32'h1);
        check("int_req_set", {31'd0, int_req_o}, 32'h1);
        exc(5'd0, 32'h0000_0300, 1'b0, 32'h0);
        check("int_exl", status_o, 32'h0000_0403);
        tick();
        check("int_req_masked", {31'd0, int_req_o}, 32'h0);
        int_i = '0;
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        check("eret_status", status_o, 32'h0000_0401);

        // Delay-slot exception, then nested AdEL
        exc(5'd12, 32'h0000_0100, 1'b1, 32'h0);
        check("ds_epc", epc_o, 32'h0000_00FC);
        check("ds_bd", {31'd0, cause_o[31]}, 32'h1);
        check("ds_exccode", {27'd0, cause_o[6:2]}, 32'd12);
        check("ds_exl", {31'd0, status_o[1]}, 32'h1);
        exc(5'd4, 32'h0000_0200, 1'b0, 32'h8000_0003);
        check("nested_epc", epc_o, 32'h0000_00FC);
        check("nested_bd", {31'd0, cause_o[31]}, 32'h1);
        check("nested_exccode", {27'd0, cause_o[6:2]}, 32'd4);
        raddr_i = 5'd8;
        #1;
`ifdef CP0_BADVADDR_EN
        check("badvaddr_read", rdata_o, 32'h8000_0003);
`else
        check("badvaddr_absent", rdata_o, 32'h0);
`endif

        // exc > eret > mtc0 on Status
        we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0;
        eret_i = 1'b1;
        exc(5'd8, 32'h0000_0400, 1'b0, 32'h0);
        we_i = 1'b0; eret_i = 1'b0;
        check("prio_status", status_o, 32'h0000_0002);
        check("prio_epc", epc_o, 32'h0000_00FC);
        check("prio_exccode", {27'd0, cause_o[6:2]}, 32'd8);
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        check("eret_alone", status_o, 32'h0);

        // No write bypass on reads
        raddr_i = 5'd14;
        we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h0000_1234;
        #1;
        check("no_bypass_old", rdata_o, 32'h0000_00FC);
        tick();
        we_i = 1'b0;
        check("no_bypass_new", rdata_o, 32'h0000_1234);

        // Asynchronous reset mid-run
        mtc0(5'd9, 32'h0000_0055);
        check("count55", count_o, 32'h0000_0055);
        raddr_i = 5'd15;
        rst = 1'b1;
        #1;
        check("arst_count", count_o, 32'h0);
        check("arst_status", status_o, 32'h1000_0000);
        check("arst_epc", epc_o, 32'h0);
        check("arst_cause", cause_o, 32'h0);
        check("arst_rdata", rdata_o, 32'h0);
        check("arst_int_req", {30'd0, timer_int_o, int_req_o}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("prid_after_rst", rdata_o, 32'h0087_0102);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
